// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared types and constants for the PISO serializer slice.
//               Holds the state encoding used by the FSM and the default
//               word width, which matches the downstream 4-bit SIPO stage.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

  // Default data word width; matches the SIPO capture stage downstream.
  localparam int DEFAULT_WIDTH = 4;

  // State encodings, kept explicit so the register width is fixed.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_period_div.sv
`default_nettype none
// ============================================================================
// Module      : bit_period_div
// Description : Bit-period divider. Counts 0..DIV-1 while a frame is active
//               and raises a registered tick on the last clock of each bit
//               period. tick_next is the value tick will take after the next
//               edge, so the parent can register strobes aligned with tick.
//               With DIV=1 no counter exists and the tick simply follows the
//               active state.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_period_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,         // frame active this cycle
  input  logic en_next,    // frame active next cycle
  output logic tick,       // last clock of the current bit period
  output logic tick_next   // tick value for the next cycle
);

  generate
    if (DIV == 1) begin : g_div_one
      // Every active clock is a bit boundary; the counter is not needed.
      logic unused_en;
      assign unused_en = en;
      assign tick_next = en_next;
    end else begin : g_div_n
      localparam int DW = $clog2(DIV);
      localparam logic [DW-1:0] LAST = DW'(DIV - 1);

      logic [DW-1:0] cnt;
      logic [DW-1:0] cnt_next;

      // Advance the divider while active, wrap at the period end, park at 0 otherwise.
      always_comb begin
        cnt_next = '0;
        if (en && (cnt != LAST)) begin
          cnt_next = cnt + DW'(1);
        end
      end

      assign tick_next = en_next && (cnt_next == LAST);

      // Divider count register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else begin
          cnt <= cnt_next;
        end
      end
    end
  endgenerate

  // Registered tick so the bit strobe comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick <= 1'b0;
    end else begin
      tick <= tick_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out serializer, MSB-first, one bit every
//               DIV clocks, with a valid/ready load handshake, a one-cycle
//               bit strobe and a frame-done pulse on the final bit. The last
//               bit cycle also opens din_ready so frames can run back-to-back.
//               Optional build macro PISO_PARITY_EN appends an even-parity
//               bit period after the data bits.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DIV   = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_done,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  // Parity rides as an extra LSB so it shifts out after the data bits.
  localparam int SR_W = WIDTH + 1;
`else
  localparam int SR_W = WIDTH;
`endif

  // Bit counter must hold the full frame length, parity bit included.
  localparam int BC_W = (CNT_W > $clog2(SR_W + 1)) ? CNT_W : $clog2(SR_W + 1);
  localparam logic [BC_W-1:0] FRAME_BITS = BC_W'(SR_W);
  localparam logic [BC_W-1:0] ONE_BIT    = BC_W'(1);

  state_t            state;
  state_t            state_next;
  logic [SR_W-1:0]   shift_reg;
  logic [SR_W-1:0]   shift_next;
  logic [SR_W-1:0]   load_word;
  logic [BC_W-1:0]   bit_cnt;
  logic [BC_W-1:0]   bit_cnt_next;
  logic              tick;
  logic              tick_next;
  logic              in_shift;
  logic              last_bit;
  logic              accept;
  logic              frame_done_next;

`ifdef PISO_PARITY_EN
  assign load_word = {din, ^din};
`else
  assign load_word = din;
`endif

  assign in_shift = (state == SHIFT);
  assign last_bit = in_shift && tick && (bit_cnt == ONE_BIT);

  bit_period_div #(
    .DIV (DIV)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (in_shift),
    .en_next   (state_next == SHIFT),
    .tick      (tick),
    .tick_next (tick_next)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode: load from idle, and either chain or finish on the last bit.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (din_valid) state_next = SHIFT;
      SHIFT:   if (last_bit && !din_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: ready in idle or on the last bit; datapath next values.
  always_comb begin
    din_ready       = (state == IDLE) || last_bit;
    accept          = din_valid && din_ready;
    shift_next      = shift_reg;
    bit_cnt_next    = bit_cnt;
    if (accept) begin
      shift_next   = load_word;
      bit_cnt_next = FRAME_BITS;
    end else if (in_shift && tick) begin
      shift_next   = {shift_reg[SR_W-2:0], 1'b0};
      bit_cnt_next = bit_cnt - ONE_BIT;
    end
    frame_done_next = tick_next && (bit_cnt_next == ONE_BIT);
  end

  // Datapath registers; the shift register drains to zero so the line idles low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      shift_reg  <= shift_next;
      bit_cnt    <= bit_cnt_next;
      frame_done <= frame_done_next;
    end
  end

  assign serial_out = shift_reg[SR_W-1];
  assign bit_valid  = tick;
  assign busy       = in_shift;

endmodule
`default_nettype wire
